execute_cycle: RTL and testbench
================================

// Module: execute_cycle
// PURPOSE
//  EX stage of the 5-stage RV32I pipeline, directly downstream of alu_decoder.
//  - Consumes ALUControlE plus the ID/EX operands.
//  - Selects forwarded operands and runs the ALU.
//  - Resolves beq and computes the branch target.
//  - Owns the EX/MEM pipeline register, with stall and flush (bubble) control.
// PARAMETERS
//  XLEN   32  datapath width
//  RADDR   5  register-file address width
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-low reset
//  stall_i       in   1      hold EX/MEM contents
//  flush_i       in   1      load a bubble into EX/MEM
//  RegWriteE     in   1      control from ID/EX
//  MemWriteE     in   1      control from ID/EX
//  ResultSrcE    in   1      control from ID/EX
//  BranchE       in   1      control from ID/EX
//  ALUSrcE       in   1      0: operand B = forwarded RD2; 1: operand B = Imm_Ext_E
//  ALUControlE   in   3      from alu_decoder
//  RD1_E         in   XLEN   register operand 1
//  RD2_E         in   XLEN   register operand 2
//  Imm_Ext_E     in   XLEN   sign-extended immediate
//  PCE           in   XLEN   PC of the EX instruction
//  PCPlus4E      in   XLEN   PC + 4
//  RD_E          in   RADDR  destination register
//  ForwardA_E    in   2      forwarding select for operand A
//  ForwardB_E    in   2      forwarding select for operand B
//  ResultW       in   XLEN   writeback result (forward source)
//  PCSrcE        out  1      branch taken (combinational)
//  PCTargetE     out  XLEN   PCE + Imm_Ext_E (combinational, wraps mod 2^XLEN)
//  RegWriteM     out  1      registered control
//  MemWriteM     out  1      registered control
//  ResultSrcM    out  1      registered control
//  ALU_ResultM   out  XLEN   registered ALU result
//  WriteDataM    out  XLEN   registered store data = forwarded B, pre-ALUSrc mux
//  RD_M          out  RADDR  registered destination register
//  PCPlus4M      out  XLEN   registered PC + 4
//  valid_m       out  1      EX/MEM holds a real instruction
// BEHAVIOUR
//  ALU encoding:
//  - 000 ADD; 001 SUB; 010 AND; 011 OR; 101 SLT (signed; result 1 or 0).
//  - 100, 110, 111 -> result 0.
//  - ADD and SUB wrap mod 2^XLEN; no overflow flag.
//  ZeroE = (alu result == 0); PCSrcE = BranchE & ZeroE.
//  Latency: one cycle from E inputs to *M outputs.
//  Clock-edge priority:
//  - rst low (async): every registered output = 0, valid_m = 0.
//  - flush_i: RegWriteM = MemWriteM = ResultSrcM = valid_m = 0.
//    Data fields are don't-care; implementation drives them to 0.
//  - stall_i: all *M registers hold their values.
//  - otherwise: load E values; valid_m = 1.
//  Simultaneous flush_i and stall_i: flush wins.
//  Combinational outputs (PCSrcE, PCTargetE) ignore stall and flush.
//  Reset deasserted mid-stream: first load occurs on the next rising edge.
//  RD_E = 0 with RegWriteE = 1 passes through unchanged; x0 is suppressed in the regfile.
// CONFIGURATION
//  Macro EX_FWD_EN:
//  - Defined: each ForwardX_E selects the ALU operand.
//    00 -> RDx_E, 01 -> ResultW, 10 -> ALU_ResultM, 11 -> RDx_E.
//    Operand B forwarding also feeds WriteDataM.
//  - Undefined: ForwardA_E, ForwardB_E and ResultW are ignored.
//    Operands are RD1_E and RD2_E directly. Ports remain present.
// STRUCTURE
//  Package alu_pkg:
//  - ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT localparams.
//  - FWD_RF, FWD_WB, FWD_MEM localparams.
//  - XLEN default.
//  Sub-module alu: pure combinational; inputs a, b, ctrl; outputs result, zero.
//  Forwarding muxes, branch logic and EX/MEM register stay in execute_cycle.
// TESTING
//  1. rst=0 mid-run with valid_m=1 -> all *M outputs = 0 and valid_m = 0 immediately, before any clock edge.
//  2. RD1=7, RD2=9, ALUControlE=001 -> ALU_ResultM=32'hFFFF_FFFE next edge.
//     Same operands with ALUControlE=101 -> ALU_ResultM=1.
//  3. BranchE=1, RD1=RD2=5, SUB, PCE=0x100, Imm=0x20 -> PCSrcE=1 and PCTargetE=0x120 in the same cycle.
//  4. stall_i=1 for 3 cycles while E inputs change -> *M outputs unchanged.
//     stall_i=flush_i=1 -> valid_m=0, RegWriteM=0.
//  5. EX_FWD_EN defined, ForwardA_E=10, ALU_ResultM=0x10, RD1=0, Imm=4, ALUSrcE=1, ADD -> ALU_ResultM=0x14.
//     Without the macro -> ALU_ResultM=4.
//  6. ALUSrcE=1, ForwardB_E=01, ResultW=0xAB, MemWriteE=1 -> WriteDataM=0xAB (macro on).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation codes, forwarding selects and default datapath width shared by the EX stage.
package alu_pkg;
    localparam int XLEN = 32;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
endpackage

// File: rtl/execute_cycle_if.sv
// execute_cycle_if: ID/EX inputs, EX/MEM outputs and stall/flush control of the EX stage.
interface execute_cycle_if import alu_pkg::*; #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int RADDR = 5
);
    logic             stall_i;
    logic             flush_i;
    logic             RegWriteE;
    logic             MemWriteE;
    logic             ResultSrcE;
    logic             BranchE;
    logic             ALUSrcE;
    logic [2:0]       ALUControlE;
    logic [XLEN-1:0]  RD1_E;
    logic [XLEN-1:0]  RD2_E;
    logic [XLEN-1:0]  Imm_Ext_E;
    logic [XLEN-1:0]  PCE;
    logic [XLEN-1:0]  PCPlus4E;
    logic [RADDR-1:0] RD_E;
    logic [1:0]       ForwardA_E;
    logic [1:0]       ForwardB_E;
    logic [XLEN-1:0]  ResultW;
    logic             PCSrcE;
    logic [XLEN-1:0]  PCTargetE;
    logic             RegWriteM;
    logic             MemWriteM;
    logic             ResultSrcM;
    logic [XLEN-1:0]  ALU_ResultM;
    logic [XLEN-1:0]  WriteDataM;
    logic [RADDR-1:0] RD_M;
    logic [XLEN-1:0]  PCPlus4M;
    logic             valid_m;

    modport slave (
        input  stall_i, flush_i, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardA_E, ForwardB_E, ResultW,
        output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALU_ResultM, WriteDataM,
               RD_M, PCPlus4M, valid_m
    );

    modport master (
        output stall_i, flush_i, RegWriteE, MemWriteE, ResultSrcE, BranchE, ALUSrcE, ALUControlE,
               RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, ForwardA_E, ForwardB_E, ResultW,
        input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, ALU_ResultM, WriteDataM,
               RD_M, PCPlus4M, valid_m
    );
endinterface

// File: rtl/alu.sv
// alu: combinational RV32I ALU (ADD/SUB/AND/OR/SLT); unused opcodes yield zero.
module alu import alu_pkg::*; #(
    parameter int XLEN = alu_pkg::XLEN
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      ctrl,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    always_comb begin
        result = ctrl == ALU_ADD ? a + b :
                 ctrl == ALU_SUB ? a - b :
                 ctrl == ALU_AND ? a & b :
                 ctrl == ALU_OR  ? a | b :
                 ctrl == ALU_SLT ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} :
                 '0;
        zero   = result == '0;
    end
endmodule

// File: rtl/execute_cycle.sv
// execute_cycle: RV32I EX stage with operand forwarding, beq resolution and the EX/MEM register.
// Define EX_FWD_EN to enable ForwardA_E/ForwardB_E operand selection.
module execute_cycle import alu_pkg::*; #(
    parameter int XLEN  = alu_pkg::XLEN,
    parameter int RADDR = 5
) (
    input logic            clk,
    input logic            rst,
    execute_cycle_if.slave ex
);
    logic [XLEN-1:0]  src_a, src_b, op_b, alu_y;
    logic             zero, load;
    logic             reg_write_d, reg_write_q, mem_write_d, mem_write_q;
    logic             result_src_d, result_src_q, valid_d, valid_q;
    logic [XLEN-1:0]  alu_result_d, alu_result_q, write_data_d, write_data_q;
    logic [XLEN-1:0]  pc_plus4_d, pc_plus4_q;
    logic [RADDR-1:0] rd_d, rd_q;

`ifdef EX_FWD_EN
    always_comb begin
        src_a = ex.ForwardA_E == FWD_WB  ? ex.ResultW :
                ex.ForwardA_E == FWD_MEM ? alu_result_q : ex.RD1_E;
        src_b = ex.ForwardB_E == FWD_WB  ? ex.ResultW :
                ex.ForwardB_E == FWD_MEM ? alu_result_q : ex.RD2_E;
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex.ForwardA_E, ex.ForwardB_E, ex.ResultW, FWD_RF, FWD_WB, FWD_MEM};
    assign src_a = ex.RD1_E;
    assign src_b = ex.RD2_E;
`endif

    assign op_b = ex.ALUSrcE ? ex.Imm_Ext_E : src_b;

    alu #(.XLEN(XLEN)) u_alu (
        .a      (src_a),
        .b      (op_b),
        .ctrl   (ex.ALUControlE),
        .result (alu_y),
        .zero   (zero)
    );

    assign ex.PCSrcE    = ex.BranchE & zero;
    assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

    // Flush beats stall; a flushed slot clears data fields too.
    always_comb begin
        load         = !ex.flush_i && !ex.stall_i;
        reg_write_d  = ex.flush_i ? 1'b0 : load ? ex.RegWriteE  : reg_write_q;
        mem_write_d  = ex.flush_i ? 1'b0 : load ? ex.MemWriteE  : mem_write_q;
        result_src_d = ex.flush_i ? 1'b0 : load ? ex.ResultSrcE : result_src_q;
        valid_d      = ex.flush_i ? 1'b0 : load ? 1'b1          : valid_q;
        alu_result_d = ex.flush_i ? '0   : load ? alu_y         : alu_result_q;
        write_data_d = ex.flush_i ? '0   : load ? src_b         : write_data_q;
        pc_plus4_d   = ex.flush_i ? '0   : load ? ex.PCPlus4E   : pc_plus4_q;
        rd_d         = ex.flush_i ? '0   : load ? ex.RD_E       : rd_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= 1'b0;
            valid_q      <= 1'b0;
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= '0;
            rd_q         <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            valid_q      <= valid_d;
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
        end
    end

    assign ex.RegWriteM   = reg_write_q;
    assign ex.MemWriteM   = mem_write_q;
    assign ex.ResultSrcM  = result_src_q;
    assign ex.valid_m     = valid_q;
    assign ex.ALU_ResultM = alu_result_q;
    assign ex.WriteDataM  = write_data_q;
    assign ex.PCPlus4M    = pc_plus4_q;
    assign ex.RD_M        = rd_q;
endmodule

// File: tb/tb_execute_cycle.sv
// tb_execute_cycle: directed and randomized checks of execute_cycle against a behavioural EX/MEM model.
module tb_execute_cycle;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    execute_cycle_if ex();
    execute_cycle dut (.clk(clk), .rst(rst), .ex(ex));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Expected EX/MEM contents
    logic        m_rw, m_mw, m_rs, m_v;
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] opnd(input logic [31:0] rf, input logic [1:0] f);
`ifdef EX_FWD_EN
        if (f == 2'b01) return ex.ResultW;
        if (f == 2'b10) return m_alu;
`endif
        return (f == f) ? rf : rf;
    endfunction

    function automatic logic [31:0] exp_alu();
        return alu_ref(ex.ALUControlE, opnd(ex.RD1_E, ex.ForwardA_E),
                       ex.ALUSrcE ? ex.Imm_Ext_E : opnd(ex.RD2_E, ex.ForwardB_E));
    endfunction

    task automatic m_clear();
        {m_rw, m_mw, m_rs, m_v} = '0;
        m_alu = '0; m_wd = '0; m_pc4 = '0; m_rd = '0;
    endtask

    task automatic check_m(input string tag);
        chk({tag, ".RegWriteM"},   32'(ex.RegWriteM),  32'(m_rw));
        chk({tag, ".MemWriteM"},   32'(ex.MemWriteM),  32'(m_mw));
        chk({tag, ".ResultSrcM"},  32'(ex.ResultSrcM), 32'(m_rs));
        chk({tag, ".valid_m"},     32'(ex.valid_m),    32'(m_v));
        chk({tag, ".ALU_ResultM"}, ex.ALU_ResultM,     m_alu);
        chk({tag, ".WriteDataM"},  ex.WriteDataM,      m_wd);
        chk({tag, ".PCPlus4M"},    ex.PCPlus4M,        m_pc4);
        chk({tag, ".RD_M"},        32'(ex.RD_M),       32'(m_rd));
    endtask

    task automatic check_comb(input string tag);
        #1;
        chk({tag, ".PCSrcE"},    32'(ex.PCSrcE), 32'(ex.BranchE && exp_alu() == 32'd0));
        chk({tag, ".PCTargetE"}, ex.PCTargetE,   ex.PCE + ex.Imm_Ext_E);
    endtask

    task automatic step(input string tag);
        logic [31:0] y, wd;
        y  = exp_alu();
        wd = opnd(ex.RD2_E, ex.ForwardB_E);
        @(posedge clk);
        if (ex.flush_i) m_clear();
        else if (!ex.stall_i) begin
            m_rw = ex.RegWriteE; m_mw = ex.MemWriteE; m_rs = ex.ResultSrcE; m_v = 1'b1;
            m_alu = y; m_wd = wd; m_pc4 = ex.PCPlus4E; m_rd = ex.RD_E;
        end
        #1;
        check_m(tag);
    endtask

    task automatic set_e(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                         input logic [2:0] op, input logic src);
        ex.RD1_E = a; ex.RD2_E = b; ex.Imm_Ext_E = imm; ex.ALUControlE = op; ex.ALUSrcE = src;
        ex.RegWriteE = 1'b1; ex.MemWriteE = 1'b0; ex.ResultSrcE = 1'b0; ex.BranchE = 1'b0;
        ex.ForwardA_E = 2'b00; ex.ForwardB_E = 2'b00; ex.ResultW = $urandom;
        ex.PCE = $urandom; ex.PCPlus4E = $urandom; ex.RD_E = 5'($urandom);
        ex.stall_i = 1'b0; ex.flush_i = 1'b0;
    endtask

    task automatic rand_e();
        set_e($urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom));
        if ($urandom_range(0, 3) == 0) ex.RD2_E = ex.RD1_E;
        ex.RegWriteE = 1'($urandom); ex.MemWriteE = 1'($urandom);
        ex.ResultSrcE = 1'($urandom); ex.BranchE = 1'($urandom);
        ex.ForwardA_E = 2'($urandom); ex.ForwardB_E = 2'($urandom);
        ex.stall_i = $urandom_range(0, 4) == 0;
        ex.flush_i = $urandom_range(0, 9) == 0;
    endtask

    initial begin
        logic [31:0] held;
        set_e(0, 0, 0, ALU_ADD, 1'b0);
        m_clear();
        #12;
        check_m("reset");
        rst = 1'b1;
        step("first_load");

        set_e(32'd7, 32'd9, 0, ALU_SUB, 1'b0);
        step("sub");
        chk("sub_value", ex.ALU_ResultM, 32'hFFFF_FFFE);
        set_e(32'd7, 32'd9, 0, ALU_SLT, 1'b0);
        step("slt");
        chk("slt_value", ex.ALU_ResultM, 32'd1);

        set_e(32'd5, 32'd5, 32'h20, ALU_SUB, 1'b0);
        ex.BranchE = 1'b1; ex.PCE = 32'h100;
        #1;
        chk("beq_taken", 32'(ex.PCSrcE), 32'd1);
        chk("beq_target", ex.PCTargetE, 32'h120);
        step("beq");

        set_e(32'h1234, 32'h1, 0, ALU_OR, 1'b0);
        step("pre_stall");
        held = ex.ALU_ResultM;
        for (int i = 0; i < 3; i++) begin
            rand_e();
            ex.stall_i = 1'b1; ex.flush_i = 1'b0;
            step("stall");
            chk("stall_hold", ex.ALU_ResultM, held);
        end
        ex.stall_i = 1'b1; ex.flush_i = 1'b1; ex.RegWriteE = 1'b1;
        step("stall_flush");
        chk("sf_valid", 32'(ex.valid_m), 32'd0);
        chk("sf_regwrite", 32'(ex.RegWriteM), 32'd0);

        set_e(32'h10, 0, 0, ALU_ADD, 1'b0);
        step("fwd_seed");
        set_e(0, 0, 32'd4, ALU_ADD, 1'b1);
        ex.ForwardA_E = 2'b10;
        step("fwd_mem");
`ifdef EX_FWD_EN
        chk("fwd_mem_value", ex.ALU_ResultM, 32'h14);
`else
        chk("fwd_mem_value", ex.ALU_ResultM, 32'h4);
`endif

        set_e(0, 32'h55, 0, ALU_ADD, 1'b1);
        ex.ForwardB_E = 2'b01; ex.ResultW = 32'hAB; ex.MemWriteE = 1'b1;
        step("fwd_wb");
`ifdef EX_FWD_EN
        chk("store_fwd", ex.WriteDataM, 32'hAB);
`else
        chk("store_fwd", ex.WriteDataM, 32'h55);
`endif

        for (int i = 0; i < 300; i++) begin
            rand_e();
            check_comb("rand_comb");
            step("rand");
        end

        set_e(32'h3, 32'h4, 0, ALU_AND, 1'b0);
        step("pre_async");
        #2;
        rst = 1'b0;
        #1;
        m_clear();
        check_m("async_rst");
        chk("async_valid", 32'(ex.valid_m), 32'd0);
        #2;
        rst = 1'b1;
        set_e(32'h8, 32'h2, 0, ALU_SUB, 1'b0);
        step("post_rst");
        chk("post_rst_value", ex.ALU_ResultM, 32'h6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
